// File: rtl/alu_pkg.sv
// Shared ALU opcode and multi-cycle sequencer state types.
// Imported by the ALU controller, multicycle_alu and seq_muldiv.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_XOR  = 4'd1,
        OP_OR   = 4'd2,
        OP_AND  = 4'd3,
        OP_NOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SLT  = 4'd7,
        OP_ADD  = 4'd8,
        OP_ADDU = 4'd9,
        OP_SUB  = 4'd10,
        OP_SUBU = 4'd11,
        OP_MULT = 4'd12,
        OP_DIV  = 4'd13
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } muldiv_state_e;

endpackage

// File: rtl/seq_muldiv.sv
// Iterative signed multiply (shift-add) / divide (restoring) on magnitudes,
// WIDTH steps in ITER followed by a one-cycle sign fix in FIX.
module seq_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    muldiv_state_e state_reg, state_next;

    logic [CW-1:0]      cnt_reg;
    logic [WIDTH-1:0]   acc_reg;
    logic [WIDTH-1:0]   shr_reg;
    logic [WIDTH-1:0]   opnd_reg;
    logic               div_reg;
    logic               neg_lo_reg;
    logic               neg_hi_reg;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_neg;

    assign abs_a = a[WIDTH-1] ? -a : a;
    assign abs_b = b[WIDTH-1] ? -b : b;

    // acc holds the running high word (MULT) or partial remainder (DIV);
    // shr holds the multiplier bits (MULT) or dividend/quotient bits (DIV).
    assign add_sum = {1'b0, acc_reg} + (shr_reg[0] ? {1'b0, opnd_reg} : '0);
    assign trial   = {acc_reg, shr_reg[WIDTH-1]} - {1'b0, opnd_reg};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = ITER;
            ITER:    if (cnt_reg == '0) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg    <= '0;
            acc_reg    <= '0;
            shr_reg    <= '0;
            opnd_reg   <= '0;
            div_reg    <= 1'b0;
            neg_lo_reg <= 1'b0;
            neg_hi_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        cnt_reg    <= CW'(WIDTH - 1);
                        acc_reg    <= '0;
                        shr_reg    <= is_div ? abs_a : abs_b;
                        opnd_reg   <= is_div ? abs_b : abs_a;
                        div_reg    <= is_div;
                        neg_lo_reg <= a[WIDTH-1] ^ b[WIDTH-1];
                        // Remainder follows the dividend; a product's high word follows the product.
                        neg_hi_reg <= is_div ? a[WIDTH-1] : (a[WIDTH-1] ^ b[WIDTH-1]);
                    end
                end
                ITER: begin
                    cnt_reg <= cnt_reg - CW'(1);
                    if (div_reg) begin
                        if (!trial[WIDTH]) begin
                            acc_reg <= trial[WIDTH-1:0];
                            shr_reg <= {shr_reg[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_reg <= {acc_reg[WIDTH-2:0], shr_reg[WIDTH-1]};
                            shr_reg <= {shr_reg[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_reg <= add_sum[WIDTH:1];
                        shr_reg <= {add_sum[0], shr_reg[WIDTH-1:1]};
                    end
                end
                default: ;
            endcase
        end
    end

    assign prod     = {acc_reg, shr_reg};
    assign prod_neg = -prod;

    always_comb begin
        if (div_reg) begin
            lo = neg_lo_reg ? -shr_reg : shr_reg;
            hi = neg_hi_reg ? -acc_reg : acc_reg;
        end else begin
            {hi, lo} = neg_lo_reg ? prod_neg : prod;
        end
    end

    assign busy = (state_reg != IDLE);
    assign done = (state_reg == FIX);

endmodule

// File: rtl/multicycle_alu.sv
// Execute-stage ALU: single-cycle ops plus iterative MULT/DIV via seq_muldiv.
// Define ALU_FAST_MULT_EN to compute MULT combinationally in one cycle.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alu_operation,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    alu_op_e          op;
    logic             accept;
    logic             b_is_zero;
    logic             md_start;
    logic             md_busy;
    logic             md_done;
    logic [WIDTH-1:0] md_lo;
    logic [WIDTH-1:0] md_hi;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] sc_lo;
    logic [WIDTH-1:0] sc_hi;
    logic             sc_ovf;
    logic             sc_valid;
    logic             sc_zero;

    logic [WIDTH-1:0] result_reg;
    logic [WIDTH-1:0] result_hi_reg;
    logic             zero_reg;
    logic             overflow_reg;
    logic             done_reg;

    assign op        = alu_op_e'(alu_operation);
    assign accept    = start && !md_busy;
    assign b_is_zero = (b == '0);
    assign sum       = a + b;
    assign diff      = a - b;

`ifdef ALU_FAST_MULT_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    assign md_start  = accept && (op == OP_DIV) && !b_is_zero;
`else
    assign md_start  = accept && ((op == OP_MULT) || ((op == OP_DIV) && !b_is_zero));
`endif

    always_comb begin
        sc_lo    = '0;
        sc_hi    = '0;
        sc_ovf   = 1'b0;
        sc_valid = 1'b1;
        case (op)
            OP_XOR:  sc_lo = a ^ b;
            OP_OR:   sc_lo = a | b;
            OP_AND:  sc_lo = a & b;
            OP_NOR:  sc_lo = ~(a | b);
            OP_SLL:  sc_lo = b << a[SHW-1:0];
            OP_SRL:  sc_lo = b >> a[SHW-1:0];
            OP_SLT:  sc_lo = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_ADD: begin
                sc_lo  = sum;
                sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_ADDU: sc_lo = sum;
            OP_SUB: begin
                sc_lo  = diff;
                sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUBU: sc_lo = diff;
`ifdef ALU_FAST_MULT_EN
            OP_MULT: {sc_hi, sc_lo} = fast_prod;
`endif
            // Only reaches the outputs for a zero divisor; otherwise seq_muldiv runs.
            OP_DIV: begin
                sc_lo = '1;
                sc_hi = a;
            end
            // NOP and unused codes report an all-clear result with no flags.
            default: sc_valid = 1'b0;
        endcase
        sc_zero = sc_valid && (sc_lo == '0);
    end

    seq_muldiv #(
        .WIDTH(WIDTH)
    ) u_seq_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (md_start),
        .is_div (op == OP_DIV),
        .a      (a),
        .b      (b),
        .busy   (md_busy),
        .done   (md_done),
        .lo     (md_lo),
        .hi     (md_hi)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_reg    <= '0;
            result_hi_reg <= '0;
            zero_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (md_done) begin
                result_reg    <= md_lo;
                result_hi_reg <= md_hi;
                zero_reg      <= (md_lo == '0);
                overflow_reg  <= 1'b0;
                done_reg      <= 1'b1;
            end else if (accept && !md_start) begin
                result_reg    <= sc_lo;
                result_hi_reg <= sc_hi;
                zero_reg      <= sc_zero;
                overflow_reg  <= sc_ovf;
                done_reg      <= 1'b1;
            end
        end
    end

    assign result    = result_reg;
    assign result_hi = result_hi_reg;
    assign zero      = zero_reg;
    assign overflow  = overflow_reg;
    assign done      = done_reg;
    assign busy      = md_busy;

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu (WIDTH=32); honours ALU_FAST_MULT_EN.
// Expected results are queued at issue time and compared when done pulses.
module tb_multicycle_alu;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        z;
        logic        ov;
    } vec_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        z;
        logic        ov;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  alu_operation = 4'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] result;
    logic [31:0] result_hi;
    logic        zero;
    logic        overflow;
    logic        busy;
    logic        done;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;
    exp_t sb[$];
    vec_t tbl[16];

    multicycle_alu #(.WIDTH(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .alu_operation (alu_operation),
        .a             (a),
        .b             (b),
        .result        (result),
        .result_hi     (result_hi),
        .zero          (zero),
        .overflow      (overflow),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic int lat_of(logic [3:0] op, logic [31:0] y);
`ifdef ALU_FAST_MULT_EN
        if (op == 4'd12) return 1;
`else
        if (op == 4'd12) return 34;
`endif
        if (op == 4'd13 && y != 0) return 34;
        return 1;
    endfunction

    function automatic vec_t model(logic [3:0] op, logic [31:0] x, logic [31:0] y);
        vec_t   v;
        longint sx;
        longint sy;
        longint q;
        longint r;
        logic [63:0] p;
        sx = $signed(x);
        sy = $signed(y);
        v.op = op; v.a = x; v.b = y; v.lo = '0; v.hi = '0; v.ov = 1'b0;
        case (op)
            4'd1:  v.lo = x ^ y;
            4'd2:  v.lo = x | y;
            4'd3:  v.lo = x & y;
            4'd4:  v.lo = ~(x | y);
            4'd5:  v.lo = y << x[4:0];
            4'd6:  v.lo = y >> x[4:0];
            4'd7:  v.lo = (sx < sy) ? 32'd1 : 32'd0;
            4'd8:  begin v.lo = x + y; v.ov = (x[31] == y[31]) && (v.lo[31] != x[31]); end
            4'd9:  v.lo = x + y;
            4'd10: begin v.lo = x - y; v.ov = (x[31] != y[31]) && (v.lo[31] != x[31]); end
            4'd11: v.lo = x - y;
            4'd12: begin p = sx * sy; v.hi = p[63:32]; v.lo = p[31:0]; end
            4'd13: begin
                if (y == 0) begin
                    v.lo = '1; v.hi = x;
                end else begin
                    q = sx / sy; r = sx % sy;
                    v.lo = q[31:0]; v.hi = r[31:0];
                end
            end
            default: ;
        endcase
        v.z = (op != 4'd0 && op <= 4'd13) ? (v.lo == 0) : 1'b0;
        return v;
    endfunction

    // Drives one request for a cycle; call while the DUT is not busy.
    task automatic issue(input vec_t v);
        exp_t e;
        e.op = v.op; e.lo = v.lo; e.hi = v.hi; e.z = v.z; e.ov = v.ov;
        e.lat = lat_of(v.op, v.b);
        e.acc = cyc + 1;
        sb.push_back(e);
        alu_operation = v.op;
        a = v.a;
        b = v.b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain_timeout: %0d results outstanding after %0d cycles", sb.size(), t);
            sb.delete();
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check($sformatf("op%0d result", e.op), result, e.lo);
                check($sformatf("op%0d result_hi", e.op), result_hi, e.hi);
                check($sformatf("op%0d zero", e.op), 32'(zero), 32'(e.z));
                check($sformatf("op%0d overflow", e.op), 32'(overflow), 32'(e.ov));
                check($sformatf("op%0d latency", e.op), 32'(cyc + 1 - e.acc), 32'(e.lat));
                $display("op=%0d result=%h result_hi=%h zero=%0d ovf=%0d lat=%0d",
                         e.op, result, result_hi, zero, overflow, cyc + 1 - e.acc);
            end
        end
    end

    initial begin
        vec_t v;
        int   n_done;
        bit   seen;

        tbl[0]  = '{4'd8,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 1'b0, 1'b1};
        tbl[1]  = '{4'd9,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 1'b0, 1'b0};
        tbl[2]  = '{4'd10, 32'h00000005, 32'h00000005, 32'h00000000, 32'h0, 1'b1, 1'b0};
        tbl[3]  = '{4'd7,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0, 1'b0, 1'b0};
        tbl[4]  = '{4'd5,  32'h00000004, 32'h00000001, 32'h00000010, 32'h0, 1'b0, 1'b0};
        tbl[5]  = '{4'd15, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 32'h0, 1'b0, 1'b0};
        tbl[6]  = '{4'd12, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0, 1'b0};
        tbl[7]  = '{4'd13, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0};
        tbl[8]  = '{4'd13, 32'h00000009, 32'h00000000, 32'hFFFFFFFF, 32'h00000009, 1'b0, 1'b0};
        tbl[9]  = '{4'd6,  32'h00000004, 32'h80000000, 32'h08000000, 32'h0, 1'b0, 1'b0};
        tbl[10] = '{4'd10, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0, 1'b0, 1'b1};
        tbl[11] = '{4'd11, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0, 1'b0, 1'b0};
        tbl[12] = '{4'd4,  32'h0F0F0000, 32'h00FF00FF, 32'hF000FF00, 32'h0, 1'b0, 1'b0};
        tbl[13] = '{4'd13, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 1'b0};
        tbl[14] = '{4'd12, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 1'b1, 1'b0};
        tbl[15] = '{4'd7,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 32'h0, 1'b1, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset result", result, 32'h0);
        check("reset result_hi", result_hi, 32'h0);
        check("reset flags", {28'h0, zero, overflow, busy, done}, 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Table: single-cycle entries run back-to-back, iterative ones drain first
        for (int i = 0; i < 16; i++) begin
            issue(tbl[i]);
            if (lat_of(tbl[i].op, tbl[i].b) > 1) wait_drain();
        end
        wait_drain();

        // MULT busy window, with an ADD request that must be ignored while busy
        v = model(4'd12, 32'hFFFFFFFD, 32'h00000007);
        issue(v);
`ifdef ALU_FAST_MULT_EN
        @(negedge clk);
        check("fast mult busy", 32'(busy), 32'd0);
        check("fast mult done", 32'(done), 32'd1);
`else
        for (int k = 0; k < 33; k++) begin
            @(negedge clk);
            check($sformatf("mult busy k=%0d", k), 32'(busy), 32'd1);
            if (k == 5) begin
                alu_operation = 4'd8; a = 32'd1; b = 32'd2; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        check("mult busy end", 32'(busy), 32'd0);
        check("mult done end", 32'(done), 32'd1);
`endif
        wait_drain();

        // Start in the done cycle of a MULT/DIV must be accepted
        issue(model(4'd13, 32'd100, 32'd7));
        seen = 1'b0;
        for (int t = 0; t < 60 && !seen; t++) begin
            @(negedge clk);
            seen = done;
        end
        check("done seen", 32'(seen), 32'd1);
        issue(model(4'd8, 32'd3, 32'd4));
        wait_drain();

        // Reset asserted in cycle N+10 of a MULT aborts it
        issue(model(4'd12, 32'hFFFFFFFD, 32'h00000007));
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort result", result, 32'h0);
        check("abort result_hi", result_hi, 32'h0);
        check("abort flags", {28'h0, zero, overflow, busy, done}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        n_done = 0;
        for (int t = 0; t < 45; t++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("done after abort", 32'(n_done), 32'd0);
        @(posedge clk);
        #1;

        // Random sweep against the reference model
        for (int i = 0; i < 30; i++) begin
            logic [3:0]  rop;
            logic [31:0] ra;
            logic [31:0] rb;
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = (i % 3 == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            if (i % 3 == 1) rb = -rb;
            issue(model(rop, ra, rb));
            wait_drain();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
